fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage of the pipelined core. It owns the fetch PC and issues requests to an instruction memory with a request/grant/response handshake and variable latency. Returned words are buffered in a small in-order queue, and the queue head is presented to the decode pipeline register as InstrF/PCF/PCPlus4F with a valid flag. It also handles hazard-unit stalls and execute-stage redirects (taken branch/jump), discarding wrong-path responses that are still in flight.

Parameters:
PC_WIDTH, 32, width of all PC/address signals
INSTRUCTION_WIDTH, 32, instruction word width
QUEUE_DEPTH, 4, instruction queue entries; also the limit on (outstanding + queued); power of 2, >=2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset
StallF_i  in  1  hazard unit: decode cannot accept this cycle
Redirect_i  in  1  PCSrcE: redirect fetch to RedirectPC_i
RedirectPC_i  in  PC_WIDTH  PCTargetE
imem_req_o  out  1  fetch request valid
imem_addr_o  out  PC_WIDTH  fetch address
imem_gnt_i  in  1  request accepted (req&gnt = handshake)
imem_rvalid_i  in  1  response valid, in request order
imem_rdata_i  in  INSTRUCTION_WIDTH  response word
Valid_o  out  1  queue head valid
InstrF_o  out  INSTRUCTION_WIDTH  head instruction; NOP 32'h0000_0013 when Valid_o=0
PCF_o  out  PC_WIDTH  head PC; 0 when Valid_o=0
PCPlus4F_o  out  PC_WIDTH  PCF_o+4 (modulo 2^PC_WIDTH); 0 when Valid_o=0

Behaviour:
- Reset: one clock, synchronous, active-high. In the reset cycle and after it: fetch_pc=RESET_PC, queue empty, outstanding=0, drop=0, imem_req_o=0, Valid_o=0, InstrF_o=NOP, PCF_o=PCPlus4F_o=0. Reset mid-operation discards everything. Responses that arrive after reset and belong to pre-reset requests are not tracked; the memory must be reset together with this block.
- Issue: imem_req_o = !rst_i && (outstanding + occupancy < QUEUE_DEPTH) && !Redirect_i. imem_addr_o=fetch_pc. On req&gnt: fetch_pc += 4 (wraps at 2^PC_WIDTH) and outstanding++. imem_req_o may drop without a grant. The address is held stable while req=1 and gnt=0.
- Response: on imem_rvalid_i, outstanding--. If drop>0: drop-- and the word is discarded. Otherwise {pc, rdata} is written to the queue tail and is visible at the head the next cycle (no bypass). The PC of each entry comes from a response-PC counter that advances on each accepted response.
- Dequeue: when Valid_o && !StallF_i at the clock edge. Enqueue and dequeue in the same cycle are allowed, including when the queue is full. Credit accounting guarantees no overflow. Asserting rvalid with outstanding==0 is illegal (assertion).
- Redirect (Redirect_i=1): at the edge, the queue is flushed and fetch_pc and the response-PC counter both load {RedirectPC_i[PC_WIDTH-1:2],2'b00}. drop is set to the outstanding count after that cycle's updates, so a response in the same cycle is consumed first. No request is issued during the redirect cycle.
- Redirect has priority over StallF_i and over an enqueue in the same cycle.
- Latency: with gnt tied high and rvalid one cycle after grant, the first request is issued in cycle 0 (first cycle with rst_i=0), the response arrives in cycle 1, and Valid_o=1 in cycle 2. Steady-state throughput is 1 instruction/cycle.
- Counters are sized $clog2(QUEUE_DEPTH)+1 bits.

Decomposition:
- Package fetch_pkg: NOP_INSTR constant (32'h0000_0013), DEFAULT_RESET_PC, and the packed struct fetch_entry_t {pc, instr}.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t with push, pop, flush, full, empty and count.
- Issue/credit/drop logic stays in fetch_unit.

Test Plan:
1. Reset release; gnt=1; rdata=0xA0000000+addr, rvalid 1 cycle after grant; StallF=0 -> Valid_o rises in cycle 2, PCF_o sequence 0,4,8,C; PCPlus4F_o=PCF_o+4; InstrF_o matches.
2. StallF=1 from cycle 3 for 6 cycles -> queue fills to 4; imem_req_o drops when outstanding+occupancy=4; the head is held at the same PC; after release, the sequence continues with no gaps or duplicates.
3. gnt=1, response latency 3 cycles (2 in flight); Redirect_i=1 with RedirectPC_i=0x100 -> both in-flight responses discarded; next Valid_o shows PCF_o=0x100, then 0x104.
4. Redirect_i and rvalid in the same cycle, with StallF=1 -> that response is discarded and the queue empties next cycle; RedirectPC_i=0x203 -> fetch address 0x200.
5. gnt held low for 5 cycles -> imem_addr_o is stable at the pending PC; no PC advance; Valid_o=0 with InstrF_o=0x00000013 once the queue drains.
6. Redirect to 0xFFFF_FFFC -> fetch addresses 0xFFFF_FFFC then 0x0000_0000; PCPlus4F_o for the first entry=0x0000_0000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// A queue entry pairs a fetched word with the PC it was fetched from.
package fetch_pkg;

    localparam int FETCH_PC_WIDTH    = 32;
    localparam int FETCH_INSTR_WIDTH = 32;

    localparam logic [FETCH_INSTR_WIDTH-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [FETCH_PC_WIDTH-1:0]    DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [FETCH_PC_WIDTH-1:0]    pc;
        logic [FETCH_INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small in-order FIFO of fetched {pc, instr} entries with flush.
// The head is read combinationally, so a write is visible one cycle later.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               pushData,
    input  logic                       pop,
    output fetch_entry_t               headData,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  wrPtrReg;
    logic [PW-1:0]  rdPtrReg;
    logic [CW-1:0]  countReg;
    logic           doPush;
    logic           doPop;

    assign full     = (countReg == CW'(DEPTH));
    assign empty    = (countReg == '0);
    assign count    = countReg;
    assign headData = mem[rdPtrReg];

    // When full, a push is only legal alongside a pop: the freed head slot becomes the tail.
    assign doPush = push && (!full || pop);
    assign doPop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (doPush) wrPtrReg <= wrPtrReg + PW'(1);
            if (doPop)  rdPtrReg <= rdPtrReg + PW'(1);
            countReg <= countReg + CW'(doPush) - CW'(doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !flush && !rst) begin
            mem[wrPtrReg] <= pushData;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues req/gnt requests with credit
// limiting, buffers in-order responses and drops wrong-path responses after a redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    PC_WIDTH          = FETCH_PC_WIDTH,
    parameter int                    INSTRUCTION_WIDTH = FETCH_INSTR_WIDTH,
    parameter int                    QUEUE_DEPTH       = 4,
    parameter logic [PC_WIDTH-1:0]   RESET_PC          = DEFAULT_RESET_PC
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          StallF_i,
    input  logic                          Redirect_i,
    input  logic [PC_WIDTH-1:0]           RedirectPC_i,
    output logic                          imem_req_o,
    output logic [PC_WIDTH-1:0]           imem_addr_o,
    input  logic                          imem_gnt_i,
    input  logic                          imem_rvalid_i,
    input  logic [INSTRUCTION_WIDTH-1:0]  imem_rdata_i,
    output logic                          Valid_o,
    output logic [INSTRUCTION_WIDTH-1:0]  InstrF_o,
    output logic [PC_WIDTH-1:0]           PCF_o,
    output logic [PC_WIDTH-1:0]           PCPlus4F_o
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    logic [PC_WIDTH-1:0]  fetchPcReg, fetchPcNext;
    logic [PC_WIDTH-1:0]  respPcReg, respPcNext;
    logic [PC_WIDTH-1:0]  redirectPc;
    logic [PC_WIDTH-1:0]  headPc;
    logic [CW-1:0]        outstandingReg, outstandingNext;
    logic [CW-1:0]        dropReg, dropNext;
    logic [CW-1:0]        queueCount;
    logic [CW:0]          inUse;
    logic                 queueFull, queueEmpty;
    logic                 issue, accept, headValid, pop;
    fetch_entry_t         pushEntry, headEntry;

    assign redirectPc = RedirectPC_i & ~PC_WIDTH'(3);

    // Credits cover both requests in flight and words already queued, so the queue never overflows.
    assign inUse       = {1'b0, outstandingReg} + {1'b0, queueCount};
    assign imem_req_o  = !rst_i && (inUse < (CW+1)'(QUEUE_DEPTH)) && !Redirect_i;
    assign imem_addr_o = fetchPcReg;

    assign issue     = imem_req_o && imem_gnt_i;
    assign accept    = imem_rvalid_i && (dropReg == '0);
    assign headValid = !rst_i && !queueEmpty;
    assign pop       = headValid && !StallF_i;

    always_comb begin
        fetchPcNext     = fetchPcReg;
        respPcNext      = respPcReg;
        outstandingNext = outstandingReg;
        dropNext        = dropReg;
        if (issue) begin
            fetchPcNext     = fetchPcReg + PC_WIDTH'(4);
            outstandingNext = outstandingNext + CW'(1);
        end
        if (imem_rvalid_i) begin
            outstandingNext = outstandingNext - CW'(1);
            if (dropReg != '0) dropNext   = dropReg - CW'(1);
            else               respPcNext = respPcReg + PC_WIDTH'(4);
        end
        // Everything still in flight after this cycle belongs to the abandoned path.
        if (Redirect_i) begin
            fetchPcNext = redirectPc;
            respPcNext  = redirectPc;
            dropNext    = outstandingNext;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetchPcReg     <= RESET_PC;
            respPcReg      <= RESET_PC;
            outstandingReg <= '0;
            dropReg        <= '0;
        end else begin
            fetchPcReg     <= fetchPcNext;
            respPcReg      <= respPcNext;
            outstandingReg <= outstandingNext;
            dropReg        <= dropNext;
        end
    end

    assign pushEntry.pc    = FETCH_PC_WIDTH'(respPcReg);
    assign pushEntry.instr = FETCH_INSTR_WIDTH'(imem_rdata_i);

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk      (clk_i),
        .rst      (rst_i),
        .flush    (Redirect_i),
        .push     (accept),
        .pushData (pushEntry),
        .pop      (pop),
        .headData (headEntry),
        .full     (queueFull),
        .empty    (queueEmpty),
        .count    (queueCount)
    );

    assign headPc     = PC_WIDTH'(headEntry.pc);
    assign Valid_o    = headValid;
    assign InstrF_o   = headValid ? INSTRUCTION_WIDTH'(headEntry.instr) : INSTRUCTION_WIDTH'(NOP_INSTR);
    assign PCF_o      = headValid ? headPc : '0;
    assign PCPlus4F_o = headValid ? headPc + PC_WIDTH'(4) : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(imem_rvalid_i && outstandingReg == '0));
            assert (!(accept && queueFull && !pop && !Redirect_i));
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic, checked every cycle
// against a request-tagging reference model and a variable-latency memory model.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        StallF_i;
    logic        Redirect_i;
    logic [31:0] RedirectPC_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        Valid_o;
    logic [31:0] InstrF_o;
    logic [31:0] PCF_o;
    logic [31:0] PCPlus4F_o;

    always #5 clk_i = ~clk_i;

    fetch_unit dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .StallF_i      (StallF_i),
        .Redirect_i    (Redirect_i),
        .RedirectPC_i  (RedirectPC_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .Valid_o       (Valid_o),
        .InstrF_o      (InstrF_o),
        .PCF_o         (PCF_o),
        .PCPlus4F_o    (PCPlus4F_o)
    );

    typedef struct { logic [31:0] addr; int due; } mem_req_t;
    typedef struct { logic [31:0] addr; bit stale; } flight_t;

    mem_req_t    memQ[$];
    flight_t     flight[$];
    logic [31:0] modelQ[$];
    logic [31:0] modelPc;
    int          cyc;
    int          lastDue;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit gnt, input bit stall, input bit redir,
                        input logic [31:0] rpc, input int lat);
        bit          expReq;
        bit          expValid;
        logic [31:0] hp;
        flight_t     f;
        int          due;

        rst_i         = rst;
        imem_gnt_i    = gnt;
        StallF_i      = stall;
        Redirect_i    = redir;
        RedirectPC_i  = rpc;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
        if (!rst && memQ.size() > 0 && memQ[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = 32'hA000_0000 + memQ[0].addr;
            void'(memQ.pop_front());
        end
        #2;

        expReq   = !rst && (flight.size() + modelQ.size() < 4) && !redir;
        expValid = !rst && modelQ.size() > 0;
        hp       = expValid ? modelQ[0] : 32'h0;
        chk("req", {31'b0, imem_req_o}, {31'b0, expReq});
        chk("valid", {31'b0, Valid_o}, {31'b0, expValid});
        chk("pcf", PCF_o, hp);
        chk("pcplus4", PCPlus4F_o, expValid ? hp + 32'd4 : 32'h0);
        chk("instr", InstrF_o, expValid ? 32'hA000_0000 + hp : 32'h0000_0013);
        if (!rst) chk("addr", imem_addr_o, modelPc);

        if (imem_req_o && imem_gnt_i) begin
            due = cyc + lat;
            if (due < lastDue) due = lastDue;
            lastDue = due;
            memQ.push_back('{imem_addr_o, due});
        end

        if (rst) begin
            memQ.delete();
            flight.delete();
            modelQ.delete();
            modelPc = 32'h0;
            lastDue = 0;
        end else begin
            if (expValid && !stall) void'(modelQ.pop_front());
            if (imem_rvalid_i && flight.size() > 0) begin
                f = flight.pop_front();
                if (!f.stale && !redir) modelQ.push_back(f.addr);
            end
            if (expReq && gnt) begin
                flight.push_back('{modelPc, 1'b0});
                modelPc = modelPc + 32'd4;
            end
            if (redir) begin
                modelQ.delete();
                foreach (flight[i]) flight[i].stale = 1'b1;
                modelPc = rpc & ~32'd3;
            end
        end

        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    initial begin
        rst_i = 1'b1; StallF_i = 1'b0; Redirect_i = 1'b0; RedirectPC_i = '0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        cyc = 0; lastDue = 0; modelPc = 32'h0;
        @(posedge clk_i);
        #1;

        repeat (2) step(1, 1, 0, 0, 0, 1);
        // Streaming with one-cycle response latency.
        repeat (8) step(0, 1, 0, 0, 0, 1);
        // Decode stall: queue fills and requests stop at the credit limit.
        repeat (6) step(0, 1, 1, 0, 0, 1);
        repeat (6) step(0, 1, 0, 0, 0, 1);
        // Longer latency, redirect with responses still in flight.
        repeat (4) step(0, 1, 0, 0, 0, 3);
        step(0, 1, 0, 1, 32'h0000_0100, 3);
        repeat (8) step(0, 1, 0, 0, 0, 3);
        // Redirect coinciding with a response while stalled; unaligned target.
        repeat (3) step(0, 1, 0, 0, 0, 1);
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 1, 1, 32'h0000_0203, 1);
        repeat (4) step(0, 1, 0, 0, 0, 1);
        // Grant withheld: address must hold while the queue drains.
        repeat (5) step(0, 0, 0, 0, 0, 1);
        repeat (4) step(0, 1, 0, 0, 0, 1);
        // PC wrap at the top of the address space.
        step(0, 1, 0, 1, 32'hFFFF_FFFC, 1);
        repeat (6) step(0, 1, 0, 0, 0, 1);

        repeat (400) begin
            step(0, $urandom_range(0, 3) != 0, ($urandom % 10) < 3, ($urandom % 20) == 0,
                 $urandom, $urandom_range(1, 4));
        end

        // Reset in the middle of traffic, then resume.
        step(1, 1, 0, 0, 0, 1);
        repeat (8) step(0, 1, 0, 0, 0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
